// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, combinational imem address and the IF/ID pipeline register.
// Optional performance counters are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic [31:0] ifid_pc_plus4
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_s;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        load_s;
  logic        unused_redirect_lsb_s;

  // Redirect targets are word aligned; the low address bits are dropped.
  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  // Wraps modulo 2^32 naturally.
  assign pc_plus4_s = pc_q + 32'd4;
  assign load_s     = (!flush) && (!stall);
  assign imem_addr  = pc_q;

  // PC next-state: redirect beats stall.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // IF/ID next-state: flush beats stall.
  always_comb begin
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    if (flush) begin
      ifid_valid_d    = 1'b0;
      ifid_instr_d    = NOP_WORD;
      ifid_pc_d       = 32'h0000_0000;
      ifid_pc_plus4_d = 32'h0000_0000;
    end else if (stall) begin
      ifid_valid_d    = ifid_valid_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
    end else begin
      ifid_valid_d    = 1'b1;
      ifid_instr_d    = imem_rdata;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4_s;
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q            <= RESET_PC;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= NOP_WORD;
      ifid_pc_q       <= 32'h0000_0000;
      ifid_pc_plus4_q <= 32'h0000_0000;
    end else begin
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
    end
  end

  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      sat_inc = val;
    end else begin
      sat_inc = val + 32'd1;
    end
  endfunction

  // Counter next-state; a stall masked by flush is not counted as a stall.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_s) begin
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (stall && !flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_load_s;
  assign unused_load_s = load_s;
`endif

endmodule
